ex_stage_exec: RTL and testbench
================================

// Module: ex_stage_exec
// PURPOSE
//  E-stage datapath; consumes the 14-bit Ex_control_bus from the E-stage control decoder.
//  Bus fields: {DIVU,DIV,MULTU,MULT,ALUASel,ALUBSel,alu_func[3:0],AOMSel[1:0],RTMSel[1:0]}.
//  Selects operands and computes the single-cycle ALU result.
//  Runs multi-cycle MULT/DIV through a small FSM, owns the HI/LO registers, and stalls the E stage until M stage accepts.
// PARAMETERS
//  MUL_LAT    2    multiplier pipeline stages (cycles in MUL state), >=1
//  DIV_ITER   32   radix-2 restoring divider iterations; fixed at 32 for 32-bit data
//  HILO_RST   0    reset value of HI and LO
// PORTS
//  clk            in   1   clock, rising edge
//  resetn         in   1   synchronous reset, active low
//  ex_valid       in   1   E-stage instruction valid
//  ex_control_bus in   14  decoded control, field order as in PURPOSE
//  ex_mthi/ex_mtlo in  1   write HI/LO from rs (not encoded in the bus)
//  ex_flush       in   1   exception/ERET flush; kills current E instruction
//  ms_allowin     in   1   M stage can accept this cycle
//  rs_value       in   32  forwarded rs operand
//  rt_value       in   32  forwarded rt operand
//  imm_ext        in   32  extended immediate
//  sa             in   5   shift amount field
//  ex_result      out  32  ALU result (combinational)
//  ex_overflow    out  1   signed overflow; only for alu_func 0000/0001, else 0
//  ex_ready_go    out  1   E instruction may leave this cycle
//  md_busy        out  1   FSM not IDLE
//  hi_out/lo_out  out  32  architectural HI/LO (registered)
// BEHAVIOUR
//  Operands:
//   - A = ALUASel ? {27'b0,sa} : rs_value
//   - B = ALUBSel ? imm_ext : rt_value
//   - shifts: shift amount = A[4:0], shifted value = B
//  alu_func encoding:
//   - 0000 ADD, 1100 ADDU, 0001 SUB, 1101 SUBU, 0010 SLT (signed), 1011 SLTU
//   - 0011 AND, 0101 NOR, 0110 OR, 0111 XOR, 0100 LUI = {B[15:0],16'b0}
//   - 1000 SLL, 1001 SRA, 1010 SRL, 1111 none -> 0; other codes -> 0
//  Overflow: ADD -> a[31]==b[31] && r[31]!=a[31]; SUB -> a[31]!=b[31] && r[31]!=a[31].
//  FSM states IDLE, MUL, DIV, DONE; md_start = ex_valid & ~ex_flush & state==IDLE & any of bits 13:10.
//   - IDLE: ex_ready_go = ~md_start. md_start latches rs/rt and sign mode.
//     MULT/MULTU -> MUL; DIV/DIVU -> DIV.
//   - MUL: counter counts MUL_LAT cycles, then -> DONE. Product is 64-bit signed/unsigned; HI=prod[63:32], LO=prod[31:0].
//   - DIV: one restoring step per cycle for DIV_ITER cycles on magnitudes, then -> DONE.
//     Signed fixup: quotient negated if signs differ; remainder takes the dividend sign.
//   - DONE: ex_ready_go=1. If ms_allowin: write HI=remainder/prod_hi, LO=quotient/prod_lo, -> IDLE. Else hold DONE.
//  Latency from accept cycle 0:
//   - MULT reaches DONE in cycle MUL_LAT+1.
//   - DIV reaches DONE in cycle 33.
//   - ex_ready_go=0 in every cycle before DONE.
//  Division edge cases:
//   - Divisor 0: latency unchanged, LO=32'hFFFF_FFFF, HI=rs (unsigned mode). Signed mode applies the same sign fixup to those values.
//   - 0x8000_0000 / -1 (signed): LO=32'h8000_0000, HI=0, no trap.
//  MTHI/MTLO: HI or LO <= rs_value when ex_valid & ~ex_flush & ex_ready_go & ms_allowin & state==IDLE.
//  ex_flush in any state: FSM -> IDLE next cycle, counters cleared, HI/LO unchanged. Flush wins over DONE commit.
//  Inputs changing while busy are ignored; only latched operands are used.
//  Reset (resetn=0 at posedge): state=IDLE, counters=0, HI=LO=HILO_RST, latched operands=0.
//   - md_busy=0, ex_ready_go=1 with ex_valid=0.
//   - Reset mid-operation aborts with no HI/LO write.
// TESTING
//  T1: ADD rs=0x7FFF_FFFF, rt=1, bus func 0000, ALUBSel=0 -> ex_result=0x8000_0000, ex_overflow=1.
//  T2: SLL sa=4, rt=0x0000_000F, ALUASel=1 -> ex_result=0xF0; SRA A=rs=8, B=0x8000_0000 -> ex_result=0xFF80_0000.
//  T3: DIV rs=-7, rt=2, ms_allowin=1 -> ex_ready_go low for cycles 0..32, high in cycle 33; then LO=0xFFFF_FFFD, HI=0xFFFF_FFFF.
//  T4: MULTU 0xFFFF_FFFF*0xFFFF_FFFF -> DONE in cycle 3 (MUL_LAT=2); then HI=0xFFFF_FFFE, LO=1.
//  T5: DIVU by 0 with ms_allowin held low 5 cycles at DONE -> state holds DONE; on release LO=0xFFFF_FFFF, HI=rs.
//  T6: start DIV, assert ex_flush in cycle 10 (and separately resetn=0 in cycle 10) -> IDLE next cycle, HI/LO unchanged, md_busy=0.

Source files
------------

// File: rtl/ex_stage_exec.sv
// E-stage execute datapath: operand select, single-cycle ALU, and a multi-cycle
// MULT/DIV unit that owns HI/LO and holds the E stage until M stage accepts.
module ex_stage_exec #(
  parameter int unsigned MUL_LAT  = 2,
  parameter int unsigned DIV_ITER = 32,
  parameter logic [31:0] HILO_RST = 32'h0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ex_valid,
  input  logic [13:0] ex_control_bus,
  input  logic        ex_mthi,
  input  logic        ex_mtlo,
  input  logic        ex_flush,
  input  logic        ms_allowin,
  input  logic [31:0] rs_value,
  input  logic [31:0] rt_value,
  input  logic [31:0] imm_ext,
  input  logic [4:0]  sa,
  output logic [31:0] ex_result,
  output logic        ex_overflow,
  output logic        ex_ready_go,
  output logic        md_busy,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} md_state_e;

  localparam logic [7:0] MulLast = 8'(MUL_LAT - 1);
  localparam logic [7:0] DivLast = 8'(DIV_ITER - 1);

  // Control bus decode
  logic [3:0] md_op;
  logic       alu_asel, alu_bsel;
  logic [3:0] alu_func;
  logic       unused_sel;

  assign md_op      = ex_control_bus[13:10];
  assign alu_asel   = ex_control_bus[9];
  assign alu_bsel   = ex_control_bus[8];
  assign alu_func   = ex_control_bus[7:4];
  assign unused_sel = ^ex_control_bus[3:0];

  // ALU
  logic [31:0] alu_a, alu_b, add_res, sub_res, alu_res;

  assign alu_a   = alu_asel ? {27'b0, sa} : rs_value;
  assign alu_b   = alu_bsel ? imm_ext : rt_value;
  assign add_res = alu_a + alu_b;
  assign sub_res = alu_a - alu_b;

  always_comb begin
    alu_res = 32'h0;
    case (alu_func)
      4'b0000, 4'b1100: alu_res = add_res;
      4'b0001, 4'b1101: alu_res = sub_res;
      4'b0010:          alu_res = {31'b0, $signed(alu_a) < $signed(alu_b)};
      4'b1011:          alu_res = {31'b0, alu_a < alu_b};
      4'b0011:          alu_res = alu_a & alu_b;
      4'b0101:          alu_res = ~(alu_a | alu_b);
      4'b0110:          alu_res = alu_a | alu_b;
      4'b0111:          alu_res = alu_a ^ alu_b;
      4'b0100:          alu_res = {alu_b[15:0], 16'b0};
      4'b1000:          alu_res = alu_b << alu_a[4:0];
      4'b1001:          alu_res = $signed(alu_b) >>> alu_a[4:0];
      4'b1010:          alu_res = alu_b >> alu_a[4:0];
      default:          alu_res = 32'h0;
    endcase
  end

  assign ex_result   = alu_res;
  assign ex_overflow = ((alu_func == 4'b0000) && (alu_a[31] == alu_b[31]) &&
                        (add_res[31] != alu_a[31])) ||
                       ((alu_func == 4'b0001) && (alu_a[31] != alu_b[31]) &&
                        (sub_res[31] != alu_a[31]));

  // Multiply/divide unit state
  md_state_e   state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic        sgn_q, sgn_d, is_div_q, is_div_d;
  logic [31:0] rem_q, rem_d, quo_q, quo_d;
  logic [63:0] prod_q, prod_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  logic        md_start, start_sgn;
  logic [31:0] rs_mag, dvs_mag, quo_fix, rem_fix;
  logic [32:0] div_shift, div_diff;
  logic        div_ge;
  logic [63:0] mul_a_ext, mul_b_ext, mul_full;

  assign md_start  = ex_valid & ~ex_flush & (state_q == StIdle) & (|md_op);
  assign start_sgn = md_op[2] | md_op[0];
  assign rs_mag    = (start_sgn & rs_value[31]) ? -rs_value : rs_value;

  // Restoring step on magnitudes; divisor 0 naturally yields all-ones quotient.
  assign dvs_mag   = (sgn_q & b_q[31]) ? -b_q : b_q;
  assign div_shift = {rem_q, quo_q[31]};
  assign div_diff  = div_shift - {1'b0, dvs_mag};
  assign div_ge    = div_shift >= {1'b0, dvs_mag};
  assign quo_fix   = (sgn_q & (a_q[31] ^ b_q[31])) ? -quo_q : quo_q;
  assign rem_fix   = (sgn_q & a_q[31]) ? -rem_q : rem_q;

  assign mul_a_ext = {{32{sgn_q & a_q[31]}}, a_q};
  assign mul_b_ext = {{32{sgn_q & b_q[31]}}, b_q};
  assign mul_full  = mul_a_ext * mul_b_ext;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    sgn_d       = sgn_q;
    is_div_d    = is_div_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    prod_d      = prod_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    ex_ready_go = 1'b0;
    unique case (state_q)
      StIdle: begin
        ex_ready_go = ~md_start;
        if (md_start) begin
          a_d      = rs_value;
          b_d      = rt_value;
          sgn_d    = start_sgn;
          is_div_d = md_op[3] | md_op[2];
          rem_d    = 32'h0;
          quo_d    = rs_mag;
          cnt_d    = 8'h0;
          state_d  = (md_op[3] | md_op[2]) ? StDiv : StMul;
        end else if (ex_valid && !ex_flush && ms_allowin) begin
          if (ex_mthi) hi_d = rs_value;
          if (ex_mtlo) lo_d = rs_value;
        end
      end
      StMul: begin
        prod_d = mul_full;
        if (cnt_q == MulLast) begin
          cnt_d   = 8'h0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StDiv: begin
        rem_d = div_ge ? div_diff[31:0] : div_shift[31:0];
        quo_d = {quo_q[30:0], div_ge};
        if (cnt_q == DivLast) begin
          cnt_d   = 8'h0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StDone: begin
        ex_ready_go = 1'b1;
        if (ms_allowin) begin
          hi_d    = is_div_q ? rem_fix : prod_q[63:32];
          lo_d    = is_div_q ? quo_fix : prod_q[31:0];
          state_d = StIdle;
        end
      end
    endcase
    // Flush kills the instruction outright, including a pending DONE commit.
    if (ex_flush) begin
      state_d = StIdle;
      cnt_d   = 8'h0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= StIdle;
      cnt_q    <= 8'h0;
      a_q      <= 32'h0;
      b_q      <= 32'h0;
      sgn_q    <= 1'b0;
      is_div_q <= 1'b0;
      rem_q    <= 32'h0;
      quo_q    <= 32'h0;
      prod_q   <= 64'h0;
      hi_q     <= HILO_RST;
      lo_q     <= HILO_RST;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sgn_q    <= sgn_d;
      is_div_q <= is_div_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      prod_q   <= prod_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign md_busy = (state_q != StIdle);
  assign hi_out  = hi_q;
  assign lo_out  = lo_q;

endmodule

// File: tb/tb_ex_stage_exec.sv
// Directed bench for ex_stage_exec: ALU results and MULT/DIV latency, HI/LO
// commits, stall-at-DONE, MTHI/MTLO and flush/reset aborts, via a scoreboard.
module tb_ex_stage_exec;

  logic        clk = 1'b0;
  logic        resetn, ex_valid, ex_mthi, ex_mtlo, ex_flush, ms_allowin;
  logic [13:0] ex_control_bus;
  logic [31:0] rs_value, rt_value, imm_ext;
  logic [4:0]  sa;
  logic [31:0] ex_result, hi_out, lo_out;
  logic        ex_overflow, ex_ready_go, md_busy;

  int total = 0;
  int bad   = 0;
  logic [31:0] m_hi = 32'h0;
  logic [31:0] m_lo = 32'h0;
  logic [63:0] exp_q[$];
  string       tag_q[$];

  ex_stage_exec dut (
    .clk           (clk),
    .resetn        (resetn),
    .ex_valid      (ex_valid),
    .ex_control_bus(ex_control_bus),
    .ex_mthi       (ex_mthi),
    .ex_mtlo       (ex_mtlo),
    .ex_flush      (ex_flush),
    .ms_allowin    (ms_allowin),
    .rs_value      (rs_value),
    .rt_value      (rt_value),
    .imm_ext       (imm_ext),
    .sa            (sa),
    .ex_result     (ex_result),
    .ex_overflow   (ex_overflow),
    .ex_ready_go   (ex_ready_go),
    .md_busy       (md_busy),
    .hi_out        (hi_out),
    .lo_out        (lo_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [13:0] mkbus(input logic [3:0] md, input logic as, input logic bs,
                                        input logic [3:0] fn);
    return {md, as, bs, fn, 4'b1001};
  endfunction

  // Reference model for MULT/DIV results, returned as {HI, LO}
  function automatic logic [63:0] md_model(input logic [3:0] md, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [31:0] ma, mb, q, r;
    logic        s;
    longint      ps;
    logic [63:0] pu;
    if (md[0]) begin
      ps = longint'($signed(a)) * longint'($signed(b));
      return ps;
    end
    if (md[1]) begin
      pu = 64'(a) * 64'(b);
      return pu;
    end
    s  = md[2];
    ma = (s && a[31]) ? -a : a;
    mb = (s && b[31]) ? -b : b;
    if (mb == 32'h0) begin
      q = 32'hFFFF_FFFF;
      r = ma;
    end else begin
      q = ma / mb;
      r = ma % mb;
    end
    if (s && (a[31] ^ b[31])) q = -q;
    if (s && a[31]) r = -r;
    return {r, q};
  endfunction

  task automatic alu(input string tag, input logic as, input logic bs, input logic [3:0] fn,
                     input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] imm,
                     input logic [4:0] s, input logic [31:0] er, input logic eo);
    logic [63:0] e;
    string       t;
    @(posedge clk); #1;
    ex_valid       = 1'b1;
    ex_control_bus = mkbus(4'b0000, as, bs, fn);
    rs_value       = rs;
    rt_value       = rt;
    imm_ext        = imm;
    sa             = s;
    exp_q.push_back({31'b0, eo, er});
    tag_q.push_back(tag);
    @(negedge clk);
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check(t, {31'b0, ex_overflow, ex_result}, e);
  endtask

  task automatic md_run(input string tag, input logic [3:0] md, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat, input int hold);
    int          n;
    logic [63:0] e;
    string       t;
    @(posedge clk); #1;
    ex_valid       = 1'b1;
    ex_control_bus = mkbus(md, 1'b0, 1'b0, 4'b1111);
    rs_value       = a;
    rt_value       = b;
    ms_allowin     = (hold == 0);
    exp_q.push_back(md_model(md, a, b));
    tag_q.push_back(tag);
    @(negedge clk);
    check({tag, ":go_c0"}, 64'(ex_ready_go), 64'd0);
    n = 0;
    do begin
      @(posedge clk); #1;
      rs_value = $urandom;
      rt_value = $urandom;
      @(negedge clk);
      n++;
    end while (!ex_ready_go && n < 100);
    check({tag, ":latency"}, 64'(n), 64'(exp_lat));
    check({tag, ":busy_done"}, 64'(md_busy), 64'd1);
    for (int h = 1; h < hold; h++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check({tag, ":hold_go"}, {62'b0, md_busy, ex_ready_go}, 64'd3);
    end
    if (hold > 0) begin
      check({tag, ":hold_hilo"}, {hi_out, lo_out}, {m_hi, m_lo});
      @(posedge clk); #1;
      ms_allowin = 1'b1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    ex_valid = 1'b0;
    @(negedge clk);
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check(t, {hi_out, lo_out}, e);
    check({t, ":idle"}, 64'(md_busy), 64'd0);
    m_hi = e[63:32];
    m_lo = e[31:0];
  endtask

  task automatic mt(input string tag, input logic to_hi, input logic [31:0] v,
                    input logic allow, input logic fl);
    @(posedge clk); #1;
    ex_valid       = 1'b1;
    ex_control_bus = mkbus(4'b0000, 1'b0, 1'b0, 4'b1111);
    ex_mthi        = to_hi;
    ex_mtlo        = ~to_hi;
    rs_value       = v;
    ms_allowin     = allow;
    ex_flush       = fl;
    @(posedge clk); #1;
    ex_mthi  = 1'b0;
    ex_mtlo  = 1'b0;
    ex_valid = 1'b0;
    ex_flush = 1'b0;
    if (allow && !fl) begin
      if (to_hi) m_hi = v;
      else m_lo = v;
    end
    @(negedge clk);
    check(tag, {hi_out, lo_out}, {m_hi, m_lo});
  endtask

  task automatic md_abort(input string tag, input logic use_rst, input int cyc);
    @(posedge clk); #1;
    ex_valid       = 1'b1;
    ex_control_bus = mkbus(4'b0100, 1'b0, 1'b0, 4'b1111);
    rs_value       = 32'h1234_5678;
    rt_value       = 32'd3;
    ms_allowin     = 1'b0;
    for (int i = 1; i < cyc; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    if (use_rst) resetn = 1'b0;
    else ex_flush = 1'b1;
    ms_allowin = 1'b1;
    @(negedge clk);
    check({tag, ":busy_pre"}, 64'(md_busy), 64'd1);
    @(posedge clk); #1;
    resetn   = 1'b1;
    ex_flush = 1'b0;
    ex_valid = 1'b0;
    if (use_rst) begin
      m_hi = 32'h0;
      m_lo = 32'h0;
    end
    @(negedge clk);
    check({tag, ":idle"}, {62'b0, md_busy, ex_ready_go}, 64'd1);
    check({tag, ":hilo"}, {hi_out, lo_out}, {m_hi, m_lo});
    repeat (40) @(posedge clk);
    @(negedge clk);
    check({tag, ":hilo_late"}, {hi_out, lo_out}, {m_hi, m_lo});
  endtask

  initial begin
    resetn         = 1'b0;
    ex_valid       = 1'b0;
    ex_mthi        = 1'b0;
    ex_mtlo        = 1'b0;
    ex_flush       = 1'b0;
    ms_allowin     = 1'b1;
    ex_control_bus = 14'h0;
    rs_value       = 32'h0;
    rt_value       = 32'h0;
    imm_ext        = 32'h0;
    sa             = 5'd0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    check("rst_ctl", {62'b0, md_busy, ex_ready_go}, 64'd1);
    check("rst_hilo", {hi_out, lo_out}, 64'h0);

    alu("add_ovf",  0, 0, 4'b0000, 32'h7FFF_FFFF, 32'h1, 32'h0, 5'd0, 32'h8000_0000, 1);
    alu("add_neg",  0, 0, 4'b0000, 32'hFFFF_FFFF, 32'h1, 32'h0, 5'd0, 32'h0, 0);
    alu("addu",     0, 0, 4'b1100, 32'h7FFF_FFFF, 32'h1, 32'h0, 5'd0, 32'h8000_0000, 0);
    alu("sub_ovf",  0, 0, 4'b0001, 32'h8000_0000, 32'h1, 32'h0, 5'd0, 32'h7FFF_FFFF, 1);
    alu("subu",     0, 0, 4'b1101, 32'h5, 32'h7, 32'h0, 5'd0, 32'hFFFF_FFFE, 0);
    alu("slt",      0, 0, 4'b0010, 32'hFFFF_FFFF, 32'h1, 32'h0, 5'd0, 32'h1, 0);
    alu("sltu",     0, 0, 4'b1011, 32'hFFFF_FFFF, 32'h1, 32'h0, 5'd0, 32'h0, 0);
    alu("and",      0, 0, 4'b0011, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h0, 5'd0, 32'h00F0_000F, 0);
    alu("nor",      0, 0, 4'b0101, 32'hF0F0_0000, 32'h0F00_0000, 32'h0, 5'd0, 32'h000F_FFFF, 0);
    alu("or_imm",   0, 1, 4'b0110, 32'h1200_0000, 32'hFFFF_FFFF, 32'h34, 5'd0, 32'h1200_0034, 0);
    alu("xor",      0, 0, 4'b0111, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0, 5'd0, 32'hF0F0_0F0F, 0);
    alu("lui",      0, 1, 4'b0100, 32'h0, 32'h0, 32'h0000_ABCD, 5'd0, 32'hABCD_0000, 0);
    alu("sll_sa",   1, 0, 4'b1000, 32'hFFFF_FFFF, 32'hF, 32'h0, 5'd4, 32'hF0, 0);
    alu("sra_rs",   0, 0, 4'b1001, 32'h8, 32'h8000_0000, 32'h0, 5'd0, 32'hFF80_0000, 0);
    alu("srl_sa",   1, 0, 4'b1010, 32'h0, 32'h8000_0000, 32'h0, 5'd31, 32'h1, 0);
    alu("none",     0, 0, 4'b1111, 32'h1, 32'h2, 32'h0, 5'd0, 32'h0, 0);
    alu("undef",    0, 0, 4'b1110, 32'h1, 32'h2, 32'h0, 5'd0, 32'h0, 0);

    md_run("div_s",     4'b0100, 32'hFFFF_FFF9, 32'd2, 33, 0);
    md_run("multu",     4'b0010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3, 0);
    md_run("mult_s",    4'b0001, 32'hFFFF_FFFD, 32'd5, 3, 0);
    md_run("divu_zero", 4'b1000, 32'h1234_5678, 32'd0, 33, 5);
    md_run("div_ovf",   4'b0100, 32'h8000_0000, 32'hFFFF_FFFF, 33, 0);
    md_run("div_s_zero", 4'b0100, 32'hFFFF_FFF0, 32'd0, 33, 0);
    md_run("divu",      4'b1000, 32'd100, 32'd7, 33, 2);

    mt("mthi",          1'b1, 32'hCAFE_0001, 1'b1, 1'b0);
    mt("mtlo",          1'b0, 32'hBEEF_0002, 1'b1, 1'b0);
    mt("mthi_stall",    1'b1, 32'h1111_1111, 1'b0, 1'b0);
    mt("mtlo_flush",    1'b0, 32'h2222_2222, 1'b1, 1'b1);

    md_abort("flush_c10", 1'b0, 10);
    md_abort("flush_done", 1'b0, 33);
    md_abort("reset_c10", 1'b1, 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
